// File: rtl/id_ex_stage_pkg.sv
// Shared decode/execute definitions: register indices, ALU opcodes and
// the control bundle carried from ID into EX.
package id_ex_stage_pkg;

    localparam int OPW     = 4;
    localparam int ALU_OPW = OPW;
    localparam logic [3:0] PC_IDX = 4'd15;

    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MOV  = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic               rf_le;
        logic               mem_load;
        logic               mem_write;
        logic               s_bit;
        logic [ALU_OPW-1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand bypass select: EX over MEM over WB over register file.
// The PC index always takes the register-file value.
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    idx_i,
    input  logic [DW-1:0] rf_i,
    input  logic          ex_en_i,
    input  logic [3:0]    ex_idx_i,
    input  logic [DW-1:0] ex_val_i,
    input  logic          mem_en_i,
    input  logic [3:0]    mem_idx_i,
    input  logic [DW-1:0] mem_val_i,
    input  logic          wb_en_i,
    input  logic [3:0]    wb_idx_i,
    input  logic [DW-1:0] wb_val_i,
    output logic [DW-1:0] op_o
);

    always_comb begin
        op_o = rf_i;
        if (idx_i != PC_IDX) begin
            if (ex_en_i && ex_idx_i == idx_i) begin
                op_o = ex_val_i;
            end else if (mem_en_i && mem_idx_i == idx_i) begin
                op_o = mem_val_i;
            end else if (wb_en_i && wb_idx_i == idx_i) begin
                op_o = wb_val_i;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use
// detection; presents hazard-free operands and control to EX.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW  = 32,
    parameter int OPW = ALU_OPW
) (
    input  logic           Clk,
    input  logic           Rst_n,
    input  logic           id_valid,
    input  logic [DW-1:0]  PA,
    input  logic [DW-1:0]  PB,
    input  logic [DW-1:0]  PD,
    input  logic [3:0]     RA,
    input  logic [3:0]     RB,
    input  logic [3:0]     RD,
    input  logic           id_use_a,
    input  logic           id_use_b,
    input  logic           id_use_d,
    input  logic [3:0]     id_dst,
    input  logic           id_rf_le,
    input  logic           id_mem_load,
    input  logic           id_mem_write,
    input  logic           id_s_bit,
    input  logic [OPW-1:0] id_alu_op,
    input  logic [DW-1:0]  ex_alu_result,
    input  logic [3:0]     mem_rw,
    input  logic [3:0]     wb_rw,
    input  logic           mem_le,
    input  logic           wb_le,
    input  logic [DW-1:0]  mem_result,
    input  logic [DW-1:0]  wb_pw,
    input  logic           stall,
    input  logic           flush,
    output logic           load_use,
    output logic           ex_valid,
    output logic           ex_rf_le,
    output logic           ex_mem_load,
    output logic           ex_mem_write,
    output logic           ex_s_bit,
    output logic [OPW-1:0] ex_alu_op,
    output logic [3:0]     ex_dst,
    output logic [DW-1:0]  ex_a,
    output logic [DW-1:0]  ex_b,
    output logic [DW-1:0]  ex_d
);

    logic          valid_q, valid_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [3:0]    dst_q, dst_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW-1:0] fa, fb, fd;
    logic          ex_fwd;
    logic          hit_a, hit_b, hit_d;

    // A load's EX result is an address, so it must not be bypassed.
    assign ex_fwd = valid_q && ctrl_q.rf_le && !ctrl_q.mem_load;

    fwd_mux #(.DW(DW)) u_fwd_a (
        .idx_i(RA), .rf_i(PA),
        .ex_en_i(ex_fwd), .ex_idx_i(dst_q), .ex_val_i(ex_alu_result),
        .mem_en_i(mem_le), .mem_idx_i(mem_rw), .mem_val_i(mem_result),
        .wb_en_i(wb_le), .wb_idx_i(wb_rw), .wb_val_i(wb_pw),
        .op_o(fa)
    );

    fwd_mux #(.DW(DW)) u_fwd_b (
        .idx_i(RB), .rf_i(PB),
        .ex_en_i(ex_fwd), .ex_idx_i(dst_q), .ex_val_i(ex_alu_result),
        .mem_en_i(mem_le), .mem_idx_i(mem_rw), .mem_val_i(mem_result),
        .wb_en_i(wb_le), .wb_idx_i(wb_rw), .wb_val_i(wb_pw),
        .op_o(fb)
    );

    fwd_mux #(.DW(DW)) u_fwd_d (
        .idx_i(RD), .rf_i(PD),
        .ex_en_i(ex_fwd), .ex_idx_i(dst_q), .ex_val_i(ex_alu_result),
        .mem_en_i(mem_le), .mem_idx_i(mem_rw), .mem_val_i(mem_result),
        .wb_en_i(wb_le), .wb_idx_i(wb_rw), .wb_val_i(wb_pw),
        .op_o(fd)
    );

    assign hit_a = id_use_a && RA == dst_q;
    assign hit_b = id_use_b && RB == dst_q;
    assign hit_d = id_use_d && RD == dst_q;

    assign load_use = id_valid && valid_q && ctrl_q.mem_load
                   && ctrl_q.rf_le && dst_q != PC_IDX
                   && (hit_a || hit_b || hit_d);

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        dst_d   = dst_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        if (flush || (!stall && load_use)) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
            dst_d   = '0;
            a_d     = '0;
            b_d     = '0;
            d_d     = '0;
        end else if (!stall) begin
            valid_d = id_valid;
            ctrl_d  = CTRL_NOP;
            dst_d   = '0;
            if (id_valid) begin
                ctrl_d.rf_le     = id_rf_le;
                ctrl_d.mem_load  = id_mem_load;
                ctrl_d.mem_write = id_mem_write;
                ctrl_d.s_bit     = id_s_bit;
                ctrl_d.alu_op    = ALU_OPW'(id_alu_op);
                dst_d            = id_dst;
            end
            a_d = fa;
            b_d = fb;
            d_d = fd;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            dst_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            dst_q   <= dst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rf_le     = ctrl_q.rf_le;
    assign ex_mem_load  = ctrl_q.mem_load;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_s_bit     = ctrl_q.s_bit;
    assign ex_alu_op    = OPW'(ctrl_q.alu_op);
    assign ex_dst       = dst_q;
    assign ex_a         = a_q;
    assign ex_b         = b_q;
    assign ex_d         = d_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority,
// load-use bubbles, stall and flush.
module tb_id_ex_stage;

    logic        Clk, Rst_n;
    logic        id_valid;
    logic [31:0] PA, PB, PD;
    logic [3:0]  RA, RB, RD;
    logic        id_use_a, id_use_b, id_use_d;
    logic [3:0]  id_dst;
    logic        id_rf_le, id_mem_load, id_mem_write, id_s_bit;
    logic [3:0]  id_alu_op;
    logic [31:0] ex_alu_result;
    logic [3:0]  mem_rw, wb_rw;
    logic        mem_le, wb_le;
    logic [31:0] mem_result, wb_pw;
    logic        stall, flush;
    logic        load_use;
    logic        ex_valid, ex_rf_le, ex_mem_load, ex_mem_write, ex_s_bit;
    logic [3:0]  ex_alu_op;
    logic [3:0]  ex_dst;
    logic [31:0] ex_a, ex_b, ex_d;

    int pass_cnt = 0;
    int total    = 0;

    id_ex_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .id_valid(id_valid),
        .PA(PA), .PB(PB), .PD(PD), .RA(RA), .RB(RB), .RD(RD),
        .id_use_a(id_use_a), .id_use_b(id_use_b), .id_use_d(id_use_d),
        .id_dst(id_dst), .id_rf_le(id_rf_le), .id_mem_load(id_mem_load),
        .id_mem_write(id_mem_write), .id_s_bit(id_s_bit),
        .id_alu_op(id_alu_op), .ex_alu_result(ex_alu_result),
        .mem_rw(mem_rw), .wb_rw(wb_rw), .mem_le(mem_le), .wb_le(wb_le),
        .mem_result(mem_result), .wb_pw(wb_pw),
        .stall(stall), .flush(flush), .load_use(load_use),
        .ex_valid(ex_valid), .ex_rf_le(ex_rf_le),
        .ex_mem_load(ex_mem_load), .ex_mem_write(ex_mem_write),
        .ex_s_bit(ex_s_bit), .ex_alu_op(ex_alu_op), .ex_dst(ex_dst),
        .ex_a(ex_a), .ex_b(ex_b), .ex_d(ex_d)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clr();
        id_valid = 0; PA = 0; PB = 0; PD = 0; RA = 0; RB = 0; RD = 0;
        id_use_a = 0; id_use_b = 0; id_use_d = 0; id_dst = 0;
        id_rf_le = 0; id_mem_load = 0; id_mem_write = 0; id_s_bit = 0;
        id_alu_op = 0; ex_alu_result = 0; mem_rw = 0; wb_rw = 0;
        mem_le = 0; wb_le = 0; mem_result = 0; wb_pw = 0;
        stall = 0; flush = 0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 0;
        id_valid = 1; PA = $urandom; PB = $urandom; PD = $urandom;
        RA = 4'($urandom); RB = 4'($urandom); RD = 4'($urandom);
        id_use_a = 1; id_use_b = 1; id_use_d = 1;
        id_dst = 4'($urandom); id_rf_le = 1; id_mem_load = 1;
        id_mem_write = 1; id_s_bit = 1; id_alu_op = 4'($urandom);
        ex_alu_result = $urandom; mem_rw = 4'($urandom);
        wb_rw = 4'($urandom); mem_le = 1; wb_le = 1;
        mem_result = $urandom; wb_pw = $urandom; stall = 0; flush = 0;
        repeat (3) step();
        total++;
        if ({ex_valid, ex_rf_le, ex_mem_load, ex_mem_write, ex_s_bit}
            !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                {ex_valid, ex_rf_le, ex_mem_load, ex_mem_write, ex_s_bit});
        else pass_cnt++;
        total++;
        if ({ex_a, ex_b, ex_d, ex_dst, ex_alu_op} !== '0)
            $display("FAIL reset_data: got a=%h b=%h d=%h dst=%h op=%h",
                ex_a, ex_b, ex_d, ex_dst, ex_alu_op);
        else pass_cnt++;
        total++;
        if (load_use !== 1'b0)
            $display("FAIL reset_load_use: got %b want 0", load_use);
        else pass_cnt++;
        clr();
        Rst_n = 1;
        step();
        total++;
        if (ex_valid !== 1'b0 || ex_a !== 32'h0)
            $display("FAIL reset_release: got v=%b a=%h want 0 0",
                ex_valid, ex_a);
        else pass_cnt++;
    endtask

    task automatic test_ex_fwd();
        clr();
        id_valid = 1; id_dst = 3; id_rf_le = 1; id_alu_op = 4'h2;
        id_s_bit = 1;
        step();
        total++;
        if (ex_valid !== 1 || ex_dst !== 4'd3 || ex_rf_le !== 1
            || ex_alu_op !== 4'h2 || ex_s_bit !== 1)
            $display("FAIL ex_capture: got v=%b dst=%h le=%b op=%h s=%b",
                ex_valid, ex_dst, ex_rf_le, ex_alu_op, ex_s_bit);
        else pass_cnt++;
        clr();
        id_valid = 1; id_dst = 4; id_rf_le = 1;
        RA = 3; id_use_a = 1; PA = 32'hDEAD;
        ex_alu_result = 32'h11;
        mem_le = 1; mem_rw = 3; mem_result = 32'h22;
        #1;
        total++;
        if (load_use !== 1'b0)
            $display("FAIL ex_fwd_no_lu: got %b want 0", load_use);
        else pass_cnt++;
        step();
        total++;
        if (ex_a !== 32'h11)
            $display("FAIL ex_fwd_prio: got %h want 00000011", ex_a);
        else pass_cnt++;
    endtask

    task automatic test_mem_wb_fwd();
        clr();
        id_valid = 1; id_dst = 1; id_rf_le = 1;
        RB = 5; id_use_b = 1; PB = 32'hBEEF;
        mem_le = 1; mem_rw = 5; mem_result = 32'h55;
        wb_le = 1; wb_rw = 5; wb_pw = 32'h66;
        step();
        total++;
        if (ex_b !== 32'h55)
            $display("FAIL mem_fwd: got %h want 00000055", ex_b);
        else pass_cnt++;
        mem_le = 0;
        step();
        total++;
        if (ex_b !== 32'h66)
            $display("FAIL wb_fwd: got %h want 00000066", ex_b);
        else pass_cnt++;
        RB = 15; PB = 32'h100; mem_le = 1; mem_rw = 15; wb_rw = 15;
        id_dst = 15;
        step();
        RB = 15; id_dst = 1; ex_alu_result = 32'h999;
        step();
        total++;
        if (ex_b !== 32'h100)
            $display("FAIL pc_no_fwd: got %h want 00000100", ex_b);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        clr();
        id_valid = 1; id_dst = 2; id_rf_le = 1; id_mem_load = 1;
        step();
        total++;
        if (ex_mem_load !== 1 || ex_dst !== 4'd2)
            $display("FAIL lu_load_in_ex: got ld=%b dst=%h want 1 2",
                ex_mem_load, ex_dst);
        else pass_cnt++;
        clr();
        id_valid = 1; id_dst = 6; id_rf_le = 1;
        RD = 2; id_use_d = 1; PD = 32'hAAAA;
        #1;
        total++;
        if (load_use !== 1'b1)
            $display("FAIL lu_detect: got %b want 1", load_use);
        else pass_cnt++;
        step();
        total++;
        if (ex_valid !== 0 || ex_rf_le !== 0 || ex_d !== 32'h0)
            $display("FAIL lu_bubble: got v=%b le=%b d=%h want 0 0 0",
                ex_valid, ex_rf_le, ex_d);
        else pass_cnt++;
        mem_le = 1; mem_rw = 2; mem_result = 32'h77;
        step();
        total++;
        if (ex_d !== 32'h77 || ex_valid !== 1 || ex_dst !== 4'd6)
            $display("FAIL lu_mem_fwd: got d=%h v=%b dst=%h want 77 1 6",
                ex_d, ex_valid, ex_dst);
        else pass_cnt++;
        clr();
        id_valid = 1; id_dst = 2; id_rf_le = 1; id_mem_load = 1;
        step();
        clr();
        id_valid = 1; id_dst = 6; id_rf_le = 1;
        RD = 2; id_use_d = 0; RA = 2; id_use_a = 0; PD = 32'h3333;
        ex_alu_result = 32'h4444;
        #1;
        total++;
        if (load_use !== 1'b0)
            $display("FAIL lu_unused: got %b want 0", load_use);
        else pass_cnt++;
        step();
        total++;
        if (ex_valid !== 1 || ex_d !== 32'h3333)
            $display("FAIL lu_no_ex_fwd: got v=%b d=%h want 1 3333",
                ex_valid, ex_d);
        else pass_cnt++;
        clr();
        id_valid = 1; id_dst = 15; id_rf_le = 1; id_mem_load = 1;
        step();
        clr();
        id_valid = 1; RA = 15; id_use_a = 1;
        #1;
        total++;
        if (load_use !== 1'b0)
            $display("FAIL lu_pc: got %b want 0", load_use);
        else pass_cnt++;
        clr();
        id_valid = 1; id_dst = 2; id_rf_le = 1; id_mem_load = 1;
        step();
        clr();
        id_valid = 1; id_dst = 5; id_rf_le = 1;
        RA = 2; id_use_a = 1; stall = 1;
        #1;
        step();
        total++;
        if (load_use !== 1 || ex_mem_load !== 1 || ex_dst !== 4'd2)
            $display("FAIL lu_stall_hold: got lu=%b ld=%b dst=%h",
                load_use, ex_mem_load, ex_dst);
        else pass_cnt++;
        stall = 0; flush = 1;
        #1;
        total++;
        if (load_use !== 1'b1)
            $display("FAIL lu_flush_out: got %b want 1", load_use);
        else pass_cnt++;
        step();
        total++;
        if (ex_valid !== 0 || ex_rf_le !== 0)
            $display("FAIL lu_flush_bubble: got v=%b le=%b want 0 0",
                ex_valid, ex_rf_le);
        else pass_cnt++;
    endtask

    task automatic test_stall_flush();
        clr();
        id_valid = 1; id_dst = 7; id_rf_le = 1; id_alu_op = 4'h5;
        id_mem_write = 1; RA = 15; id_use_a = 1; PA = 32'h1234;
        step();
        total++;
        if (ex_a !== 32'h1234 || ex_alu_op !== 4'h5 || ex_mem_write !== 1)
            $display("FAIL sf_capture: got a=%h op=%h mw=%b",
                ex_a, ex_alu_op, ex_mem_write);
        else pass_cnt++;
        stall = 1; id_dst = 8; PA = 32'hFFFF; id_alu_op = 4'h3;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (ex_a !== 32'h1234 || ex_dst !== 4'd7
                || ex_alu_op !== 4'h5 || ex_valid !== 1)
                $display("FAIL stall_hold_%0d: got a=%h dst=%h op=%h v=%b",
                    i, ex_a, ex_dst, ex_alu_op, ex_valid);
            else pass_cnt++;
        end
        flush = 1;
        step();
        total++;
        if (ex_valid !== 0 || ex_rf_le !== 0 || ex_mem_write !== 0
            || ex_alu_op !== 4'h0 || ex_a !== 32'h0)
            $display("FAIL flush_over_stall: got v=%b le=%b mw=%b op=%h a=%h",
                ex_valid, ex_rf_le, ex_mem_write, ex_alu_op, ex_a);
        else pass_cnt++;
    endtask

    task automatic test_invalid_capture();
        clr();
        id_valid = 0; id_rf_le = 1; id_mem_write = 1; id_alu_op = 4'h9;
        step();
        total++;
        if (ex_valid !== 0 || ex_rf_le !== 0 || ex_mem_write !== 0
            || ex_alu_op !== 4'h0)
            $display("FAIL invalid_ctrl: got v=%b le=%b mw=%b op=%h",
                ex_valid, ex_rf_le, ex_mem_write, ex_alu_op);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        clr();
        id_valid = 1; id_dst = 9; id_rf_le = 1; RA = 15; PA = 32'hCAFE;
        step();
        total++;
        if (ex_a !== 32'hCAFE || ex_valid !== 1)
            $display("FAIL mid_pre: got a=%h v=%b want cafe 1",
                ex_a, ex_valid);
        else pass_cnt++;
        #2;
        Rst_n = 0;
        #1;
        total++;
        if (ex_valid !== 0 || ex_a !== 32'h0 || ex_rf_le !== 0
            || ex_dst !== 4'h0)
            $display("FAIL mid_reset: got v=%b a=%h le=%b dst=%h",
                ex_valid, ex_a, ex_rf_le, ex_dst);
        else pass_cnt++;
        clr();
        step();
        Rst_n = 1;
        step();
    endtask

    initial begin
        clr();
        Rst_n = 0;
        test_reset();
        test_ex_fwd();
        test_mem_wb_fwd();
        test_load_use();
        test_stall_flush();
        test_invalid_capture();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage that sits directly downstream of the three-port register file. It captures the PA/PB/PD operands and decoded control for one instruction per cycle. It resolves data hazards by forwarding from EX, MEM and WB, and detects load-use hazards. It presents registered, hazard-free operands and control to the execute stage.

## Interface
Parameters:
- DW, 32, datapath width
- OPW, 4, ALU opcode width

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- PA, PB, PD  in  DW  register-file read data for RA, RB, RD
- RA, RB, RD  in  4  source register indices
- id_use_a, id_use_b, id_use_d  in  1  instruction actually reads that source
- id_dst  in  4  destination register index
- id_rf_le, id_mem_load, id_mem_write, id_s_bit  in  1  decoded control
- id_alu_op  in  OPW  ALU operation
- ex_alu_result  in  DW  combinational result of the instruction now in EX
- mem_rw, wb_rw  in  4  destination index in MEM, WB
- mem_le, wb_le  in  1  write enable in MEM, WB
- mem_result, wb_pw  in  DW  value to be written from MEM, WB
- stall  in  1  global freeze
- flush  in  1  kill the instruction entering EX (taken branch)
- load_use  out  1  combinational hazard; upstream must hold PC and IF/ID
- ex_valid, ex_rf_le, ex_mem_load, ex_mem_write, ex_s_bit  out  1  registered control
- ex_alu_op  out  OPW
- ex_dst  out  4
- ex_a, ex_b, ex_d  out  DW  registered, forwarded operands

## Operation
- Forwarding applies per operand (A/B/D) on the ID-side index, using a fixed priority.
  - First priority, EX: this block's own ex_valid && ex_rf_le && !ex_mem_load && ex_dst==idx supplies ex_alu_result.
  - Second priority, MEM: mem_le && mem_rw==idx supplies mem_result.
  - Third priority, WB: wb_le && wb_rw==idx supplies wb_pw.
  - Otherwise the register-file value is used.
- Index 15 (PC) is never forwarded. The register file already returns the PC for it.
- load_use = id_valid && ex_valid && ex_mem_load && ex_rf_le && ex_dst!=15 && any used source index == ex_dst.
  - Unused sources (id_use_x=0) never raise it.
- Register update priority at each posedge:
  - flush: insert a bubble. ex_valid and all control outputs go to 0; operands go to 0.
  - else stall: hold all outputs.
  - else load_use: insert a bubble, same as flush.
  - else: capture id_* control and the forwarded operands. ex_valid becomes id_valid.
- When id_valid=0 and the stage captures, the control outputs are forced to 0. A bubble never writes.
- Widths are exact. No arithmetic is done here.

## Timing
- Reset (Rst_n low, asynchronous): every output register goes to 0. load_use therefore evaluates to 0.
- Latency: 1 cycle from the ID inputs to the ex_* outputs.
- load_use is combinational in the same cycle as the ID inputs. Its two sources:
  - registered EX state;
  - the ID-stage indices and use flags.
- A load-use costs exactly one bubble. On the next cycle the load is in MEM, and the MEM forward path supplies the data.
- Simultaneous events:
  - flush+stall: flush wins.
  - flush+load_use: flush wins, and load_use still drives out in that cycle.
  - stall+load_use: hold, and load_use stays asserted.
- Deassertion of Rst_n mid-operation: the stage restarts empty (all bubbles).

## Structure
- Shared package, with constants:
  - PC_IDX=15;
  - OPW;
  - ALU opcode enum, shared with the ALU and the decoder.
- Package typedefs:
  - ctrl_t packed struct {rf_le, mem_load, mem_write, s_bit, alu_op};
  - the bubble constant CTRL_NOP.
- Sub-module fwd_mux: inputs are idx, rf value and the three forward sources; output is the selected operand. It is instantiated three times.

## Test plan
- Reset: hold Rst_n=0 with random inputs, then release. All outputs are 0 and load_use=0. Assert Rst_n low mid-stream: outputs clear immediately.
- EX forward: instruction 1 writes R3 (ex_alu_result=0x11). Next, instruction 2 uses RA=3 with PA=0xDEAD → ex_a=0x11. Set mem_rw=3 with 0x22 at the same time → ex_a is still 0x11 (EX priority).
- MEM/WB forward: mem writes R5=0x55 and wb writes R5=0x66 while RB=5 → ex_b=0x55. With mem_le=0 → ex_b=0x66. With RB=15 and PB=0x100 → ex_b=0x100.
- Load-use: a load to R2 is in EX and the next instruction uses RD=2 → load_use=1 and a bubble enters (ex_valid=0). Next cycle, with mem_result=0x77 → ex_d=0x77. With id_use_d=0 → load_use=0.
- Stall/flush: stall=1 for 3 cycles → outputs held. flush=1 with stall=1 → ex_valid=0 and all control 0 on the next edge.
